// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: Fibonacci LFSR burst sequencer with valid/ready output and zero-state lockup detection.
// Optional: define LFSR_LOCKUP_RECOVER_EN to substitute 1 for a zero state and keep the burst running.
module lfsr_burst_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic [WIDTH-1:0] cfg_taps,
    input  logic [CNT_W-1:0] cfg_len,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err_lockup,
    output logic [CNT_W-1:0] words_sent
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LFSR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] taps_q, taps_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             err_q, err_d;

    logic             fb;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [CNT_W-1:0] words_inc;
    logic             xfer;

    assign fb        = ^(lfsr_q & taps_q);
    assign lfsr_nxt  = {lfsr_q[WIDTH-2:0], fb};
    assign words_inc = words_q + CNT_ONE;
    assign xfer      = (state_q == S_RUN) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            taps_q  <= '0;
            len_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            taps_q  <= taps_d;
            len_q   <= len_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        taps_d  = taps_q;
        len_d   = len_q;
        words_d = words_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    taps_d  = cfg_taps;
                    len_d   = cfg_len;
                    words_d = '0;
                    err_d   = 1'b0;
                    lfsr_d  = cfg_seed;
                    if (cfg_len == '0) begin
                        state_d = S_DONE;
                    end else if (cfg_seed == '0) begin
                        err_d = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
                        lfsr_d  = LFSR_ONE;
                        state_d = S_RUN;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                // The final word ends the burst before any lockup check on the advance.
                if (xfer) begin
                    words_d = words_inc;
                    if (words_inc == len_q) begin
                        state_d = S_DONE;
                    end else if (lfsr_nxt == '0) begin
                        err_d = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
                        lfsr_d = LFSR_ONE;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        lfsr_d = lfsr_nxt;
                    end
                end
                if (abort) begin
                    state_d = S_IDLE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data   = lfsr_q;
    assign out_valid  = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE);
    // An abort landing on the DONE cycle suppresses the pulse.
    assign done       = (state_q == S_DONE) && !abort;
    assign err_lockup = err_q;
    assign words_sent = words_q;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Self-checking bench for lfsr_burst_ctrl (WIDTH=4) against a queue-based reference of the burst contents.
module tb_lfsr_burst_ctrl;
    localparam int W  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  cfg_seed = '0;
    logic [W-1:0]  cfg_taps = '0;
    logic [CW-1:0] cfg_len = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          err_lockup;
    logic [CW-1:0] words_sent;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    int         exp_n;
    logic       exp_err;

    always #5 clk = ~clk;

    lfsr_burst_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_len(cfg_len),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err_lockup(err_lockup), .words_sent(words_sent)
    );

    // Next word: shift left by one (multiply by 2 modulo 16), new bit 0 = parity of tapped bits.
    function automatic logic [3:0] step(input logic [3:0] cur, input logic [3:0] t);
        int fb;
        fb = $countones(cur & t) % 2;
        return 4'((int'(cur) * 2 + fb) % 16);
    endfunction

    task automatic gen_expected(input logic [3:0] seed, input logic [3:0] taps, input logic [15:0] len);
        logic [3:0] cur;
        logic [3:0] nxt;
        exp_q.delete();
        exp_err = 1'b0;
        if (len != 0) begin
            cur = seed;
            if (seed == 4'd0) begin
                exp_err = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
                cur = 4'd1;
`endif
            end
            if (cur != 4'd0) begin
                exp_q.push_back(cur);
                for (int k = 1; k < int'(len); k++) begin
                    nxt = step(cur, taps);
                    if (nxt == 4'd0) begin
                        exp_err = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
                        nxt = 4'd1;
`else
                        break;
`endif
                    end
                    cur = nxt;
                    exp_q.push_back(cur);
                end
            end
        end
        exp_n = exp_q.size();
    endtask

    task automatic run_burst(input logic [3:0] seed, input logic [3:0] taps, input logic [15:0] len,
                             input int rmode, input int abort_at, input bit abort_rdy,
                             input bit poke, input bit gen, input string nm);
        int got;
        bit fin, aborted, poked;
        if (gen) gen_expected(seed, taps, len);
        @(negedge clk);
        cfg_seed = seed; cfg_taps = taps; cfg_len = len;
        start = 1'b1; abort = 1'b0; out_ready = 1'b0;
        got = 0; fin = 0; aborted = 0; poked = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            if (aborted) begin
                abort = 1'b0; out_ready = 1'b0;
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort_idle: valid=%b busy=%b done=%b, need 0 0 0", nm, out_valid, busy, done);
                end
                checks++;
                if (words_sent !== 16'(abort_at + int'(abort_rdy))) begin
                    errors++;
                    $display("FAIL %s abort_words: got %0d need %0d", nm, words_sent, abort_at + int'(abort_rdy));
                end
                fin = 1;
            end else begin
                start = 1'b0; abort = 1'b0;
                case (rmode)
                    0: out_ready = 1'b1;
                    1: out_ready = (c % 3 == 0);
                    default: out_ready = 1'($urandom % 2);
                endcase
                if (c == 0) begin
                    checks++;
                    if (exp_n > 0 && out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL %s latency: out_valid=%b need 1", nm, out_valid);
                    end else if (exp_n == 0 && (out_valid !== 1'b0 || done !== 1'b1)) begin
                        errors++;
                        $display("FAIL %s latency: valid=%b done=%b need 0 1", nm, out_valid, done);
                    end
                end
                if (abort_at >= 0 && got == abort_at && out_valid === 1'b1) begin
                    abort = 1'b1; out_ready = abort_rdy; aborted = 1;
                end
                if (poke && !poked && got == 2 && out_valid === 1'b1) begin
                    start = 1'b1; cfg_seed = ~seed; cfg_taps = ~taps; cfg_len = 16'd3; poked = 1;
                end
                if (out_valid === 1'b1) begin
                    checks++;
                    if (got >= exp_n) begin
                        errors++;
                        $display("FAIL %s extra_word: got word %h beyond %0d words", nm, out_data, exp_n);
                    end else if (out_data !== exp_q[got]) begin
                        errors++;
                        $display("FAIL %s data[%0d]: got %h need %h", nm, got, out_data, exp_q[got]);
                    end
                    if (out_ready) got++;
                end
                if (done === 1'b1) begin
                    checks++;
                    if (got != exp_n || words_sent !== 16'(exp_n)) begin
                        errors++;
                        $display("FAIL %s count: transfers=%0d words_sent=%0d need %0d", nm, got, words_sent, exp_n);
                    end
                    checks++;
                    if (err_lockup !== exp_err) begin
                        errors++;
                        $display("FAIL %s err_lockup: got %b need %b", nm, err_lockup, exp_err);
                    end
                    checks++;
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s valid_in_done: got %b need 0", nm, out_valid);
                    end
                    @(negedge clk);
                    checks++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL %s after_done: done=%b busy=%b need 0 0", nm, done, busy);
                    end
                    fin = 1;
                end
            end
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout: burst did not finish, transfers=%0d need %0d", nm, got, exp_n);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_lockup !== 1'b0 ||
            words_sent !== 16'd0 || out_data !== 4'd0) begin
            errors++;
            $display("FAIL reset: valid=%b busy=%b done=%b err=%b words=%0d data=%h need all 0",
                     out_valid, busy, done, err_lockup, words_sent, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: valid=%b busy=%b done=%b need 0 0 0", out_valid, busy, done);
        end
    endtask

    task automatic test_basic();
        logic [3:0] ref_seq [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                     4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
        exp_q.delete();
        foreach (ref_seq[i]) exp_q.push_back(ref_seq[i]);
        exp_n = 16; exp_err = 1'b0;
        run_burst(4'b0001, 4'b1100, 16'd16, 0, -1, 1'b0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_backpressure();
        run_burst(4'b0001, 4'b1100, 16'd16, 1, -1, 1'b0, 1'b0, 1'b1, "backpressure");
    endtask

    task automatic test_zero_seed();
        exp_q.delete();
`ifdef LFSR_LOCKUP_RECOVER_EN
        exp_q.push_back(4'h1); exp_q.push_back(4'h2); exp_q.push_back(4'h4);
        exp_q.push_back(4'h9); exp_q.push_back(4'h3);
`endif
        exp_n = exp_q.size(); exp_err = 1'b1;
        run_burst(4'b0000, 4'b1100, 16'd5, 0, -1, 1'b0, 1'b0, 1'b0, "zero_seed");
    endtask

    task automatic test_degenerate_taps();
        exp_q.delete();
        exp_q.push_back(4'h8);
`ifdef LFSR_LOCKUP_RECOVER_EN
        exp_q.push_back(4'h1); exp_q.push_back(4'h3); exp_q.push_back(4'h7);
        exp_q.push_back(4'hF); exp_q.push_back(4'hF); exp_q.push_back(4'hF); exp_q.push_back(4'hF);
`endif
        exp_n = exp_q.size(); exp_err = 1'b1;
        run_burst(4'b1000, 4'b0001, 16'd8, 0, -1, 1'b0, 1'b0, 1'b0, "degenerate_taps");
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        cfg_seed = 4'b0011; cfg_taps = 4'b1100; cfg_len = 16'd4;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b valid=%b done=%b need 0 0 0", busy, out_valid, done);
        end
        checks++;
        if (err_lockup !== 1'b1) begin
            errors++;
            $display("FAIL start_abort_idle_err: err_lockup=%b need 1 (start was not accepted)", err_lockup);
        end
    endtask

    task automatic test_len_zero();
        run_burst(4'b0101, 4'b1100, 16'd0, 0, -1, 1'b0, 1'b0, 1'b1, "len_zero");
    endtask

    task automatic test_abort();
        run_burst(4'b0001, 4'b1100, 16'd16, 0, 3, 1'b0, 1'b0, 1'b1, "abort");
        run_burst(4'b0110, 4'b1001, 16'd10, 0, 4, 1'b1, 1'b0, 1'b1, "abort_with_xfer");
    endtask

    task automatic test_start_while_busy();
        run_burst(4'b0001, 4'b1100, 16'd12, 0, -1, 1'b0, 1'b1, 1'b1, "start_busy");
    endtask

    task automatic test_random();
        logic [3:0]  s, t;
        logic [15:0] l;
        for (int i = 0; i < 10; i++) begin
            s = 4'($urandom);
            t = 4'($urandom);
            l = 16'($urandom_range(0, 20));
            gen_expected(s, t, l);
            if (i % 3 == 2 && exp_n >= 3)
                run_burst(s, t, l, 2, int'($urandom_range(0, exp_n - 2)), 1'($urandom % 2), 1'b0, 1'b0, "random_abort");
            else
                run_burst(s, t, l, 2, -1, 1'b0, 1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        cfg_seed = 4'b0001; cfg_taps = 4'b1100; cfg_len = 16'd16;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: out_valid=%b need 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || words_sent !== 16'd0 || out_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b done=%b words=%0d data=%h need all 0",
                     out_valid, busy, done, words_sent, out_data);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_seed();
        test_start_abort_idle();
        test_degenerate_taps();
        test_len_zero();
        test_abort();
        test_start_while_busy();
        test_random();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_burst_ctrl.md
Name: lfsr_burst_ctrl

Overview:
Sequencer for a configurable Fibonacci LFSR pattern generator. Software or upstream logic loads seed, tap mask and burst length, then pulses start. The block streams exactly cfg_len LFSR words over a valid/ready interface, then pulses done. It is the shared PRBS source for BIST and scrambler-test paths. Zero-state lockup is detected and reported.

Parameters:
WIDTH, 16, LFSR register width in bits (min 2)
CNT_W, 16, width of burst-length and word counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a burst; sampled only in IDLE
abort  input  1  terminate the current burst; returns to IDLE
cfg_seed  input  WIDTH  initial LFSR state, latched on accepted start
cfg_taps  input  WIDTH  feedback tap mask, latched on accepted start
cfg_len  input  CNT_W  number of words to emit, latched on accepted start
out_data  output  WIDTH  current LFSR word
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts the word
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse after the last word is transferred
err_lockup  output  1  sticky: zero state detected; cleared on the next accepted start
words_sent  output  CNT_W  words transferred in current/last burst

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; LFSR reg, words_sent = 0; out_valid, busy, done, err_lockup = 0.
- Advance rule: fb = XOR-reduce(lfsr & taps_q); next = {lfsr[WIDTH-2:0], fb}. Shift left, feedback into bit 0.
- out_data = lfsr register at all times. It holds stable while out_valid && !out_ready.
- FSM states: IDLE, RUN, DONE.
- IDLE: start && !abort -> latch cfg_*; clear words_sent and err_lockup.
  - cfg_len == 0 -> DONE; no words emitted.
  - cfg_seed == 0 -> err_lockup = 1, DONE; no words emitted.
  - otherwise -> RUN, lfsr = cfg_seed.
  - Latency: start in cycle N -> out_valid = 1 with out_data = seed in cycle N+1.
- RUN: out_valid = 1. A transfer is out_valid && out_ready.
  - On a transfer: words_sent += 1 and lfsr advances.
  - If that transfer was word number len_q -> DONE; lfsr does not advance.
  - If the advanced value would be 0 -> err_lockup = 1, DONE; lfsr is not updated.
  - Back-to-back transfers sustain 1 word/cycle.
- DONE: done = 1 and out_valid = 0 for exactly one cycle -> IDLE.
- abort:
  - In RUN or DONE, abort -> IDLE next cycle; out_valid = 0; no done pulse; words_sent frozen.
  - A transfer in the same cycle as abort still counts.
  - abort and start together in IDLE: abort wins and start is ignored.
- start while busy: ignored; cfg_* changes while busy: no effect.
- words_sent does not wrap: max value is len_q <= 2^CNT_W-1.
- rst_n asserted mid-burst: immediate return to reset values; no done pulse.

Optional Feature:
LFSR_LOCKUP_RECOVER_EN
- Defined: a zero seed is replaced with 1 (bit 0 set), err_lockup still sets, and the burst runs normally. If the advanced value is 0, it is replaced with 1, err_lockup sets, and the burst continues; the full cfg_len word count is always honoured.
- Undefined: the burst terminates on lockup as described in Behaviour.

Test Plan:
- Reset: WIDTH=4; hold rst_n low, then release -> all outputs 0, IDLE. Assert rst_n low in RUN -> out_valid drops immediately (asynchronous).
- Basic sequence: WIDTH=4, taps=4'b1100, seed=4'b0001, len=16, out_ready=1.
  - Expected out_data: 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001.
  - done pulses one cycle after the 16th transfer; words_sent=16.
- Backpressure: same config; toggle out_ready 1,0,0,1,... -> out_data holds during stalls, no words skipped or duplicated, 16 transfers total.
- Zero seed: seed=0, len=5 -> macro off: err_lockup=1, no out_valid, done pulse, words_sent=0. Macro on: 5 words 0001,0010,0100,1001,0011 with err_lockup=1.
- Degenerate taps: WIDTH=4, taps=4'b0001, seed=4'b1000, len=8.
  - Expected out_data: 1000, then lockup on the next advance.
  - Macro off: words_sent=1, err_lockup=1, done. Macro on: 8 words 1000,0001,0011,0111,1111,1111,1111,1111 with err_lockup=1.
- len=0, abort, start-while-busy:
  - len=0 -> done one cycle after start, no out_valid.
  - abort after 3 transfers -> words_sent=3, no done.
  - start pulsed mid-RUN with a new seed -> sequence unaffected.
  - start+abort together in IDLE -> stays IDLE.
